// File: rtl/serial_pkg.sv
// Shared constants and deframer state encoding for the serial link receiver.
package serial_pkg;

    localparam int   DEF_DATA_W = 8;
    localparam logic START_BIT  = 1'b1;
    localparam logic IDLE_LVL   = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } rx_state_t;

endpackage

// File: rtl/serial_rx_fifo.sv
// Receive FIFO with a registered head word; pointers carry one extra bit
// so that full and empty can be told apart.
module rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [DATA_W-1:0]        o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       r_wr;
    logic [AW:0]       r_rd;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_head;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic [AW:0]       w_rd_nxt;
    logic [AW:0]       w_left;

    assign o_count   = r_wr - r_rd;
    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (o_count == (AW+1)'(DEPTH));
    assign o_head    = r_head;
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_rd_nxt  = r_rd + (AW+1)'(w_pop_ok);
    assign w_left    = o_count - (AW+1)'(w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr[AW-1:0]] <= i_data;
    end

    // Head bypasses memory when the incoming word lands in an otherwise empty FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_head <= '0;
        end else begin
            if (w_push_ok)
                r_wr <= r_wr + 1'b1;
            if (w_pop_ok)
                r_rd <= w_rd_nxt;
            if (w_push_ok && (w_left == '0))
                r_head <= i_data;
            else if (w_pop_ok && (w_left != '0))
                r_head <= r_mem[w_rd_nxt[AW-1:0]];
        end
    end

endmodule

// File: rtl/serial_rx.sv
// Serial link receiver: start-bit deframer, receive FIFO and channel_busy flow control.
// Define RX_PARITY_EN to expect an even-parity bit after the data bits.
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit
// DATA   | shifting data bits in, LSB first
// PARITY | sampling the parity bit, push if parity is even
module serial_rx
    import serial_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              item_read,
    output logic              valid,
    output logic [DATA_W-1:0] parallel_out,
    output logic              channel_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`ifdef RX_PARITY_EN
    localparam int SW = DATA_W;
`else
    localparam int SW = DATA_W - 1;
`endif

    rx_state_t         r_state;
    rx_state_t         w_state_nxt;
    logic [CW-1:0]     r_bit_cnt;
    logic [SW-1:0]     r_shift;
    logic [DATA_W-1:0] w_word;
    logic              w_push;
    logic [DATA_W-1:0] w_push_data;
    logic              w_full;
    logic              w_empty;
    logic [AW:0]       w_count;
    logic [AW:0]       w_count_nxt;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic [AW+1:0]     w_used;
    logic              r_busy;

    // Without parity the last data bit is taken straight from the line, so the
    // shift register only needs to hold the earlier DATA_W-1 bits.
`ifdef RX_PARITY_EN
    assign w_word = {serial_in, r_shift[DATA_W-1:1]};
`else
    assign w_word = {serial_in, r_shift};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_data = w_word;
        case (r_state)
            IDLE: begin
                if (serial_in == START_BIT)
                    w_state_nxt = DATA;
            end
            DATA: begin
                if (r_bit_cnt == '0) begin
`ifdef RX_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = IDLE;
                    w_push      = 1'b1;
`endif
                end
            end
            PARITY: begin
                w_state_nxt = IDLE;
`ifdef RX_PARITY_EN
                w_push      = ((^r_shift) == serial_in);
                w_push_data = r_shift;
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (r_state == IDLE)
                r_bit_cnt <= CW'(DATA_W - 1);
            else if (r_bit_cnt != '0)
                r_bit_cnt <= r_bit_cnt - 1'b1;
            if (r_state == DATA)
                r_shift <= w_word[DATA_W-1 -: SW];
        end
    end

    // A frame in flight already owns a slot; busy when one or fewer remain after that.
    assign w_push_ok   = w_push & ~w_full;
    assign w_pop_ok    = item_read & ~w_empty;
    assign w_count_nxt = w_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
    assign w_used      = {1'b0, w_count_nxt} + (AW+2)'(w_state_nxt != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_busy <= 1'b0;
        else
            r_busy <= (w_used >= (AW+2)'(DEPTH - 1));
    end

    rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (item_read),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (parallel_out)
    );

    assign valid        = ~w_empty;
    assign channel_busy = r_busy;

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx; a queue of expected words is popped and
// compared whenever the consumer reads a valid head word.
module tb_serial_rx;
    import serial_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              serial_in = IDLE_LVL;
    logic              item_read = 1'b0;
    logic              valid;
    logic [DATA_W-1:0] parallel_out;
    logic              channel_busy;

    int                n_vec  = 0;
    int                n_err  = 0;
    bit                rand_rd = 1'b0;
    logic [DATA_W-1:0] exp_q [$];

    serial_rx #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .item_read    (item_read),
        .valid        (valid),
        .parallel_out (parallel_out),
        .channel_busy (channel_busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: every consumed word must match the oldest accepted frame.
    always @(negedge clk) begin
        if (!reset && valid && item_read) begin
            logic [DATA_W-1:0] exp_w;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: parallel_out=%h, required no word", parallel_out);
            end else begin
                exp_w = exp_q.pop_front();
                if (parallel_out !== exp_w) begin
                    n_err++;
                    $display("FAIL pop_data: parallel_out=%h, required %h", parallel_out, exp_w);
                end
            end
        end
    end

    task automatic send_frame(input logic [DATA_W-1:0] w, input bit bad_par = 1'b0);
        @(posedge clk); #1;
        serial_in = START_BIT;
        if (rand_rd) item_read = 1'($urandom_range(0, 1));
        for (int i = 0; i < DATA_W; i++) begin
            @(posedge clk); #1;
            serial_in = w[i];
            if (rand_rd) item_read = 1'($urandom_range(0, 1));
        end
`ifdef RX_PARITY_EN
        @(posedge clk); #1;
        serial_in = (^w) ^ bad_par;
        if (rand_rd) item_read = 1'($urandom_range(0, 1));
`endif
        // The FIFO occupancy right now decides whether the coming edge can store it.
        if (!bad_par && exp_q.size() < DEPTH)
            exp_q.push_back(w);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            serial_in = IDLE_LVL;
        end
    endtask

    task automatic drain(input int n);
        @(posedge clk); #1;
        item_read = 1'b1;
        repeat (n) @(posedge clk);
        #1 item_read = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", valid); end
        n_vec++;
        if (parallel_out !== '0) begin n_err++; $display("FAIL reset_data: got %h, required 00", parallel_out); end
        n_vec++;
        if (channel_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", channel_busy); end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_single();
        item_read = 1'b1;
        send_frame(8'hA5);
        idle(1);
        @(negedge clk);
        n_vec++;
        if (valid !== 1'b1) begin n_err++; $display("FAIL single_valid_hi: got %b, required 1", valid); end
        @(negedge clk);
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL single_valid_lo: got %b, required 0", valid); end
        item_read = 1'b0;
    endtask

    task automatic test_back_to_back();
        item_read = 1'b0;
        send_frame(8'h01);
        send_frame(8'h02);
        send_frame(8'h03);
        idle(3);
        @(negedge clk);
        n_vec++;
        if (valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid_held: got %b, required 1", valid); end
        drain(3);
        @(negedge clk);
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b, required 0", valid); end
    endtask

    task automatic test_overflow();
        item_read = 1'b0;
        send_frame(8'h10);
        send_frame(8'h20);
        idle(3);
        @(negedge clk);
        n_vec++;
        if (channel_busy !== 1'b0) begin n_err++; $display("FAIL ovf_busy_two: got %b, required 0", channel_busy); end
        send_frame(8'h30);
        send_frame(8'h40);
        send_frame(8'h50);
        idle(3);
        @(negedge clk);
        n_vec++;
        if (channel_busy !== 1'b1) begin n_err++; $display("FAIL ovf_busy_full: got %b, required 1", channel_busy); end
        n_vec++;
        if (valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %b, required 1", valid); end
        drain(4);
        @(negedge clk);
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL ovf_fifth_dropped: valid=%b, required 0", valid); end
        n_vec++;
        if (channel_busy !== 1'b0) begin n_err++; $display("FAIL ovf_busy_clear: got %b, required 0", channel_busy); end
    endtask

    task automatic test_push_pop_same_edge();
        item_read = 1'b0;
        send_frame(8'h11);
        send_frame(8'h22);
        idle(2);
        send_frame(8'h33);
        item_read = 1'b1;
        @(posedge clk); #1;
        item_read = 1'b0;
        serial_in = IDLE_LVL;
        idle(2);
        @(negedge clk);
        n_vec++;
        if (valid !== 1'b1) begin n_err++; $display("FAIL pp_valid: got %b, required 1", valid); end
        n_vec++;
        if (channel_busy !== 1'b0) begin n_err++; $display("FAIL pp_count_two: busy=%b, required 0", channel_busy); end
        drain(2);
        @(negedge clk);
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL pp_drained: got %b, required 0", valid); end
    endtask

    task automatic test_reset_mid_frame();
        item_read = 1'b0;
        send_frame(8'h77);
        idle(2);
        @(posedge clk); #1 serial_in = START_BIT;
        @(posedge clk); #1 serial_in = 1'b1;
        @(posedge clk); #1 serial_in = 1'b0;
        @(posedge clk); #1 serial_in = 1'b1;
        #2;
        reset     = 1'b1;
        serial_in = IDLE_LVL;
        exp_q.delete();
        @(negedge clk);
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b, required 0", valid); end
        n_vec++;
        if (channel_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b, required 0", channel_busy); end
        @(posedge clk); #1 reset = 1'b0;
        item_read = 1'b1;
        send_frame(8'h3C);
        idle(1);
        @(negedge clk);
        n_vec++;
        if (valid !== 1'b1) begin n_err++; $display("FAIL midrst_rx_valid: got %b, required 1", valid); end
        @(negedge clk);
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL midrst_rx_done: got %b, required 0", valid); end
        item_read = 1'b0;
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        item_read = 1'b0;
        send_frame(8'h0F, 1'b0);
        idle(2);
        @(negedge clk);
        n_vec++;
        if (valid !== 1'b1) begin n_err++; $display("FAIL par_good_valid: got %b, required 1", valid); end
        drain(1);
        send_frame(8'h0F, 1'b1);
        idle(3);
        @(negedge clk);
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL par_bad_dropped: valid=%b, required 0", valid); end
    endtask
`endif

    task automatic test_random_stream();
        rand_rd = 1'b1;
        for (int k = 0; k < 12; k++)
            send_frame(DATA_W'($urandom));
        rand_rd   = 1'b0;
        item_read = 1'b0;
        idle(2);
        if (exp_q.size() > 0)
            drain(exp_q.size());
        @(negedge clk);
        n_vec++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL rand_drained: valid=%b, required 0", valid); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_pop_same_edge();
        test_reset_mid_frame();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
